// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: opcode encodings and flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_PASSA = 4'b0000;
    localparam logic [3:0] OP_PASSB = 4'b0001;
    localparam logic [3:0] OP_NOTA  = 4'b0010;
    localparam logic [3:0] OP_NOTB  = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_CMP   = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_OR    = 4'b1000;
    localparam logic [3:0] OP_NAND  = 4'b1001;
    localparam logic [3:0] OP_XOR   = 4'b1010;
    localparam logic [3:0] OP_LSL   = 4'b1011;
    localparam logic [3:0] OP_LSR   = 4'b1100;
    localparam logic [3:0] OP_ASL   = 4'b1101;
    localparam logic [3:0] OP_ASR   = 4'b1110;
    localparam logic [3:0] OP_CSR   = 4'b1111;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_O = 0;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the ALU and its datapath neighbours.
interface alu_if;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] FunSel;
    logic [7:0] OutALU;
    logic [3:0] Flags;

    modport master (output A, output B, output FunSel, input OutALU, input Flags);
    modport slave  (input A, input B, input FunSel, output OutALU, output Flags);
endinterface

// File: rtl/alu_flags_reg.sv
// 4-bit status register with per-bit load enables and synchronous active-high reset.
module alu_flags_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] en,
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (en[i]) q[i] <= d[i];
            end
        end
    end

endmodule

// File: rtl/alu.sv
// 8-bit ALU: combinational result, Z/C/N/O flags latched on each rising clock edge.
module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] add9;
    logic [8:0] sub9;
    logic       add_o;
    logic       sub_o;
    logic [7:0] result;
    logic [7:0] flag_res;
    logic       c_next;
    logic       o_next;
    logic       c_en;
    logic       o_en;
    logic [3:0] flag_d;
    logic [3:0] flag_en;
    logic [3:0] flags_q;

    assign a     = bus.A;
    assign b     = bus.B;
    assign add9  = {1'b0, a} + {1'b0, b};
    assign sub9  = {1'b0, a} + {1'b0, ~b} + 9'd1;
    assign add_o = (a[7] == b[7]) & (add9[7] != a[7]);
    assign sub_o = (a[7] != b[7]) & (sub9[7] != a[7]);

    always_comb begin
        result = a;
        c_next = 1'b0;
        o_next = 1'b0;
        c_en   = 1'b0;
        o_en   = 1'b0;
        case (bus.FunSel)
            OP_PASSA: result = a;
            OP_PASSB: result = b;
            OP_NOTA:  result = ~a;
            OP_NOTB:  result = ~b;
            OP_ADD: begin
                result = add9[7:0];
                c_next = add9[8];
                o_next = add_o;
                c_en   = 1'b1;
                o_en   = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                result = (bus.FunSel == OP_CMP) ? a : sub9[7:0];
                c_next = sub9[8];
                o_next = sub_o;
                c_en   = 1'b1;
                o_en   = 1'b1;
            end
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_NAND:  result = ~(a & b);
            OP_XOR:   result = a ^ b;
            OP_LSL: begin
                result = {a[6:0], 1'b0};
                c_next = a[7];
                c_en   = 1'b1;
            end
            OP_LSR: begin
                result = {1'b0, a[7:1]};
                c_next = a[0];
                c_en   = 1'b1;
            end
            OP_ASL: begin
                result = {a[6:0], 1'b0};
                c_next = a[7];
                o_next = a[7] ^ a[6];
                c_en   = 1'b1;
                o_en   = 1'b1;
            end
            OP_ASR: begin
                result = {a[7], a[7:1]};
                c_next = a[0];
                c_en   = 1'b1;
            end
            OP_CSR: begin
                result = {a[0], a[7:1]};
                c_next = a[0];
                c_en   = 1'b1;
            end
            default: result = a;
        endcase
    end

    // Compare passes A through but its Z/N describe the A-B difference.
    assign flag_res = (bus.FunSel == OP_CMP) ? sub9[7:0] : result;

    always_comb begin
        flag_d          = '0;
        flag_en         = '0;
        flag_d[FLAG_Z]  = (flag_res == 8'h00);
        flag_d[FLAG_N]  = flag_res[7];
        flag_d[FLAG_C]  = c_next;
        flag_d[FLAG_O]  = o_next;
        flag_en[FLAG_Z] = 1'b1;
        flag_en[FLAG_N] = 1'b1;
        flag_en[FLAG_C] = c_en;
        flag_en[FLAG_O] = o_en;
    end

    alu_flags_reg u_flags (
        .clk (clk),
        .rst (rst),
        .en  (flag_en),
        .d   (flag_d),
        .q   (flags_q)
    );

    assign bus.OutALU = result;
    assign bus.Flags  = flags_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal sequence plus randomized run against an arithmetic model.
module tb_alu;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   chk_en;

    alu_if ifc ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {OutALU, Flags(Z,C,N,O)} computed from the operation's arithmetic meaning.
    function automatic logic [11:0] model(input logic [3:0] prev, input logic [7:0] a8,
                                          input logic [7:0] b8, input logic [3:0] f);
        int ia, ib, sa, sb, r, fr;
        logic c, o, z, n;
        ia = int'(a8);
        ib = int'(b8);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        c  = prev[2];
        o  = prev[0];
        r  = ia;
        fr = -1;
        case (f)
            4'd0:  r = ia;
            4'd1:  r = ib;
            4'd2:  r = 255 - ia;
            4'd3:  r = 255 - ib;
            4'd4: begin
                r = (ia + ib) % 256;
                c = (ia + ib) > 255;
                o = (sa + sb > 127) || (sa + sb < -128);
            end
            4'd5, 4'd6: begin
                fr = (ia - ib + 256) % 256;
                r  = (f == 4'd5) ? fr : ia;
                c  = ia >= ib;
                o  = (sa - sb > 127) || (sa - sb < -128);
            end
            4'd7:  r = ia & ib;
            4'd8:  r = ia | ib;
            4'd9:  r = 255 - (ia & ib);
            4'd10: r = ia ^ ib;
            4'd11: begin r = (ia * 2) % 256; c = ia >= 128; end
            4'd12: begin r = ia / 2; c = (ia % 2) == 1; end
            4'd13: begin
                r = (ia * 2) % 256;
                c = ia >= 128;
                o = (ia >= 128) != (r >= 128);
            end
            4'd14: begin r = ia / 2 + ((ia >= 128) ? 128 : 0); c = (ia % 2) == 1; end
            default: begin r = ia / 2 + (ia % 2) * 128; c = (ia % 2) == 1; end
        endcase
        if (fr < 0) fr = r;
        z = (fr == 0);
        n = (fr >= 128);
        return {r[7:0], z, c, n, o};
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference flag register tracking the DUT edge by edge.
    logic [3:0]  m_flags;
    logic [11:0] m_next;
    always @(posedge clk) begin
        m_next = model(m_flags, ifc.A, ifc.B, ifc.FunSel);
        m_flags <= rst ? 4'b0000 : m_next[3:0];
    end

    logic [11:0] c_exp;
    always @(negedge clk) begin
        if (chk_en) begin
            c_exp = model(m_flags, ifc.A, ifc.B, ifc.FunSel);
            check8("model_out", ifc.OutALU, c_exp[11:4]);
            check8("model_flags", {4'h0, ifc.Flags}, {4'h0, m_flags});
        end
    end

    task automatic step(input string name, input logic r, input logic [7:0] a8, input logic [7:0] b8,
                        input logic [3:0] f, input logic [7:0] exp_out, input logic [3:0] exp_flags);
        @(negedge clk);
        #2;
        rst        = r;
        ifc.A      = a8;
        ifc.B      = b8;
        ifc.FunSel = f;
        #1;
        check8({name, "_out"}, ifc.OutALU, exp_out);
        @(posedge clk);
        #1;
        check8({name, "_flags"}, {4'h0, ifc.Flags}, {4'h0, exp_flags});
    endtask

    function automatic logic [7:0] pick_operand();
        logic [7:0] edge_vals [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 4)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        checks     = 0;
        failures   = 0;
        chk_en     = 1'b0;
        rst        = 1'b1;
        ifc.A      = 8'h00;
        ifc.B      = 8'h00;
        ifc.FunSel = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check8("reset_flags", {4'h0, ifc.Flags}, 8'h00);
        chk_en = 1'b1;

        step("add1",   1'b0, 8'h33, 8'h0F, 4'b0100, 8'h42, 4'b0000);
        step("add2",   1'b0, 8'h7F, 8'h01, 4'b0100, 8'h80, 4'b0011);
        step("sub",    1'b0, 8'h07, 8'hFA, 4'b0101, 8'h0D, 4'b0000);
        step("cmp",    1'b0, 8'h40, 8'h38, 4'b0110, 8'h40, 4'b0100);
        step("and",    1'b0, 8'hAA, 8'hF0, 4'b0111, 8'hA0, 4'b0110);
        step("or",     1'b0, 8'hAA, 8'hF0, 4'b1000, 8'hFA, 4'b0110);
        step("xor",    1'b0, 8'hAA, 8'hF0, 4'b1010, 8'h5A, 4'b0100);
        step("lsl",    1'b0, 8'h33, 8'h00, 4'b1011, 8'h66, 4'b0000);
        step("lsr",    1'b0, 8'h33, 8'h00, 4'b1100, 8'h19, 4'b0100);
        step("asl",    1'b0, 8'h80, 8'h00, 4'b1101, 8'h00, 4'b1101);
        step("asr",    1'b0, 8'h33, 8'h00, 4'b1110, 8'h19, 4'b0101);
        step("csr",    1'b0, 8'h80, 8'h00, 4'b1111, 8'h40, 4'b0001);
        step("passa",  1'b0, 8'h0F, 8'hF0, 4'b0000, 8'h0F, 4'b0001);
        step("passb",  1'b0, 8'h0F, 8'hF0, 4'b0001, 8'hF0, 4'b0011);
        step("nota",   1'b0, 8'h0F, 8'hF0, 4'b0010, 8'hF0, 4'b0011);
        step("notb",   1'b0, 8'h0F, 8'hF0, 4'b0011, 8'h0F, 4'b0001);
        step("nand",   1'b0, 8'hFF, 8'hFF, 4'b1001, 8'h00, 4'b1001);
        step("asl_pre", 1'b0, 8'h80, 8'h00, 4'b1101, 8'h00, 4'b1101);
        step("rst_mid", 1'b1, 8'h01, 8'h02, 4'b0100, 8'h03, 4'b0000);
        step("sub_wrap", 1'b0, 8'h00, 8'h01, 4'b0101, 8'hFF, 4'b0010);
        step("sub_ovf", 1'b0, 8'h80, 8'h01, 4'b0101, 8'h7F, 4'b0101);
        step("add_wrap", 1'b0, 8'hFF, 8'h01, 4'b0100, 8'h00, 4'b1100);

        repeat (3000) begin
            @(negedge clk);
            #2;
            rst        = ($urandom_range(0, 31) == 0);
            ifc.A      = pick_operand();
            ifc.B      = pick_operand();
            ifc.FunSel = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
